// File: rtl/fifo_rr_scheduler_pkg.sv
// Shared definitions for the round-robin FIFO drain scheduler.
package fifo_rr_scheduler_pkg;

  localparam int NUM_Q = 4;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_PAUSE  = 3'd4,
    ST_ERROR  = 3'd5
  } state_t;

  // Threshold values the FIFOs see until the first init load.
  localparam int AE_DEFAULT = 1;

  function automatic int af_default(input int qsize);
    return (1 << qsize) - 2;
  endfunction

endpackage

// File: rtl/fifo_rr_scheduler_rr_arbiter_4.sv
// Four-way round-robin arbiter: first requester at or after ptr, wrapping 3 -> 0.
module rr_arbiter_4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_vld
);

  // Walk offsets high to low so the smallest offset from ptr wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = ptr;
    gnt_vld = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr + 2'(k)]) begin
        gnt_idx = ptr + 2'(k);
        gnt_vld = 1'b1;
      end
    end
    if (gnt_vld) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/fifo_rr_scheduler.sv
// Drains four source FIFOs into one downstream FIFO with round-robin grants,
// a fixed 2-cycle pop-to-push pipeline, and shared threshold distribution.
module fifo_rr_scheduler #(
  parameter int DATA_SIZE       = 6,
  parameter int NUM_Q           = 4,
  parameter int MAIN_QUEUE_SIZE = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       init,
  input  logic [DATA_SIZE-1:0]       umb_af_in,
  input  logic [DATA_SIZE-1:0]       umb_ae_in,
  input  logic [NUM_Q-1:0]           q_empty,
  input  logic [NUM_Q-1:0]           q_error,
  input  logic [NUM_Q*DATA_SIZE-1:0] q_data,
  input  logic [NUM_Q-1:0]           q_enable,
  input  logic                       dn_pause,
  input  logic                       dn_error,
  output logic [NUM_Q-1:0]           q_pop,
  output logic                       dn_push,
  output logic [DATA_SIZE-1:0]       dn_data,
  output logic [DATA_SIZE-1:0]       umb_af,
  output logic [DATA_SIZE-1:0]       umb_ae,
  output logic [2:0]                 state,
  output logic                       idle
);
  import fifo_rr_scheduler_pkg::*;

  state_t           state_q, state_d;
  logic [NUM_Q-1:0] req;
  logic             err_cond;
  logic [1:0]       rr_ptr;
  logic [3:0]       gnt;
  logic [1:0]       gnt_idx;
  logic             gnt_vld;
  logic             pop_fire;
  // vld_pipe[0]: source data cycle, vld_pipe[1]: downstream push cycle
  logic [1:0]       vld_pipe;
  logic [1:0]       idx_s1;

  assign req      = ~q_empty & q_enable;
  assign err_cond = (|(q_error & q_enable)) | dn_error;

  rr_arbiter_4 u_arb (
    .req     (req),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_RESET;
    else       state_q <= state_d;
  end

  // Next state and pop decision; errors override everything except RESET.
  always_comb begin
    state_d  = state_q;
    pop_fire = 1'b0;
    q_pop    = '0;
    case (state_q)
      ST_RESET:  state_d = ST_INIT;
      ST_INIT:   if (!init) state_d = ST_IDLE;
      ST_IDLE: begin
        if (init)                      state_d = ST_INIT;
        else if (|req && !dn_pause)    state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (dn_pause)      state_d = ST_PAUSE;
        else if (!gnt_vld) state_d = ST_IDLE;
        else               pop_fire = 1'b1;
      end
      ST_PAUSE:  if (!dn_pause) state_d = (|req) ? ST_ACTIVE : ST_IDLE;
      ST_ERROR:  state_d = ST_ERROR;
      default:   state_d = ST_ERROR;
    endcase
    if (state_q != ST_RESET && err_cond) begin
      state_d  = ST_ERROR;
      pop_fire = 1'b0;
    end
    if (pop_fire) q_pop = gnt;
  end

  // Pop-to-push pipeline: index travels with the valid, slice picked in the data cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
      idx_s1   <= '0;
      dn_data  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], pop_fire};
      if (pop_fire)    idx_s1  <= gnt_idx;
      if (vld_pipe[0]) dn_data <= q_data[idx_s1*DATA_SIZE +: DATA_SIZE];
    end
  end

  // Round-robin pointer advances past each issued grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         rr_ptr <= '0;
    else if (pop_fire) rr_ptr <= gnt_idx + 2'd1;
  end

  // Threshold registers, reloaded every INIT cycle while init is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      umb_af <= DATA_SIZE'(af_default(MAIN_QUEUE_SIZE));
      umb_ae <= DATA_SIZE'(AE_DEFAULT);
    end else if (state_q == ST_INIT && init) begin
      umb_af <= umb_af_in;
      umb_ae <= umb_ae_in;
    end
  end

  assign dn_push = vld_pipe[1] && (state_q != ST_ERROR);
  assign state   = state_q;
  assign idle    = (state_q == ST_IDLE) && (vld_pipe == 2'b00);

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Directed bench for fifo_rr_scheduler with a pop/push scoreboard.
module tb_fifo_rr_scheduler;
  logic        clk = 1'b0;
  logic        reset, init;
  logic [5:0]  umb_af_in, umb_ae_in;
  logic [3:0]  q_empty, q_error, q_enable, q_pop;
  logic [23:0] q_data = '0;
  logic        dn_pause, dn_error, dn_push;
  logic [5:0]  dn_data, umb_af, umb_ae;
  logic [2:0]  state;
  logic        idle;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {logic [5:0] data; int cyc;} exp_t;
  exp_t       sb[$];
  exp_t       e;
  logic [3:0] cnt [4] = '{default: 4'd0};
  logic [3:0] gp  [8];

  always #5 clk = ~clk;

  fifo_rr_scheduler #(.DATA_SIZE(6), .NUM_Q(4), .MAIN_QUEUE_SIZE(3)) dut (
    .clk(clk), .reset(reset), .init(init), .umb_af_in(umb_af_in), .umb_ae_in(umb_ae_in),
    .q_empty(q_empty), .q_error(q_error), .q_data(q_data), .q_enable(q_enable),
    .dn_pause(dn_pause), .dn_error(dn_error), .q_pop(q_pop), .dn_push(dn_push),
    .dn_data(dn_data), .umb_af(umb_af), .umb_ae(umb_ae), .state(state), .idle(idle)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Source FIFOs: registered read data, word = {queue, sequence}.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 4; i++)
      if (q_pop[i]) begin
        q_data[i*6 +: 6] <= {2'(i), cnt[i]};
        cnt[i] <= cnt[i] + 4'd1;
      end
  end

  // Scoreboard: pops enqueue the word the source will return; pushes must match 2 cycles later.
  always @(negedge clk) begin
    if (reset || state == 3'd5) sb.delete();
    else begin
      for (int i = 0; i < 4; i++)
        if (q_pop[i]) sb.push_back('{data: {2'(i), cnt[i]}, cyc: cyc});
      if (dn_push) begin
        if (sb.size() == 0) chk("push_without_pop", 32'(dn_push), 0);
        else begin
          e = sb.pop_front();
          chk("dn_data", 32'(dn_data), 32'(e.data));
          chk("push_latency", 32'(cyc - e.cyc), 2);
        end
      end
    end
  end

  // Wait (bounded) for the first pop, then record n consecutive pop vectors.
  task automatic collect(input int n);
    int w = 0;
    @(negedge clk);
    while (q_pop == 4'd0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("pop_start_timeout", 32'(w < 20), 1);
    for (int i = 0; i < n; i++) begin
      gp[i] = q_pop;
      if (i < n - 1) @(negedge clk);
    end
  endtask

  task automatic stop_and_drain();
    @(posedge clk); #1 q_empty = 4'hF;
    repeat (4) @(negedge clk);
    chk("drain_state", 32'(state), 2);
    chk("drain_idle", 32'(idle), 1);
    chk("sb_empty", 32'(sb.size()), 0);
  endtask

  initial begin
    logic [3:0] e_all [8];
    logic [3:0] e_msk [4];
    logic [3:0] e_rot [3];
    logic [3:0] last;
    int pushes;
    e_all = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8};
    e_msk = '{4'h1, 4'h2, 4'h8, 4'h1};
    e_rot = '{4'h2, 4'h4, 4'h8};

    reset = 1; init = 0; umb_af_in = 0; umb_ae_in = 0;
    q_empty = 4'hF; q_error = 0; q_enable = 4'hF; dn_pause = 0; dn_error = 0;
    #12;
    chk("rst_state", 32'(state), 0);
    chk("rst_q_pop", 32'(q_pop), 0);
    chk("rst_dn_push", 32'(dn_push), 0);
    chk("rst_dn_data", 32'(dn_data), 0);
    chk("rst_umb_af", 32'(umb_af), 6);
    chk("rst_umb_ae", 32'(umb_ae), 1);
    chk("rst_idle", 32'(idle), 0);

    // Threshold load: init high for two INIT cycles.
    reset = 0; init = 1; umb_af_in = 6'd6; umb_ae_in = 6'd2;
    @(negedge clk);
    chk("init_state", 32'(state), 1);
    @(posedge clk); #1;
    @(posedge clk); #1 init = 0;
    @(negedge clk);
    @(negedge clk);
    chk("idle_state", 32'(state), 2);
    chk("idle_flag", 32'(idle), 1);
    chk("load_umb_af", 32'(umb_af), 6);
    chk("load_umb_ae", 32'(umb_ae), 2);

    // Full rotation over all four queues.
    @(posedge clk); #1 q_enable = 4'hF; q_empty = 4'h0;
    collect(8);
    for (int i = 0; i < 8; i++) chk("rr_all", 32'(gp[i]), 32'(e_all[i]));
    stop_and_drain();

    // Queue 2 masked off.
    @(posedge clk); #1 q_enable = 4'b1011; q_empty = 4'h0;
    collect(4);
    for (int i = 0; i < 4; i++) chk("rr_mask", 32'(gp[i]), 32'(e_msk[i]));
    stop_and_drain();

    // Downstream pause mid-stream.
    @(posedge clk); #1 q_enable = 4'hF; q_empty = 4'h0;
    collect(3);
    for (int i = 0; i < 3; i++) chk("rr_prepause", 32'(gp[i]), 32'(e_rot[i]));
    last = gp[2];
    @(posedge clk); #1 dn_pause = 1;
    @(negedge clk);
    chk("pause_pop_same_cycle", 32'(q_pop), 0);
    pushes = int'(dn_push);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) chk("pause_state", 32'(state), 4);
      chk("pause_no_pop", 32'(q_pop), 0);
      pushes += int'(dn_push);
    end
    chk("pause_inflight_pushes", 32'(pushes), 2);
    @(posedge clk); #1 dn_pause = 0;
    collect(1);
    chk("resume_next_queue", 32'(gp[0]), 32'({last[2:0], last[3]}));
    stop_and_drain();

    // Source error while active.
    @(posedge clk); #1 q_empty = 4'h0;
    collect(2);
    @(posedge clk); #1 q_error = 4'b0010;
    @(posedge clk); #1 q_error = 4'b0000;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("err_state", 32'(state), 5);
      chk("err_q_pop", 32'(q_pop), 0);
      chk("err_dn_push", 32'(dn_push), 0);
      @(negedge clk);
    end

    // Reset pulse leaves ERROR and restores defaults.
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    chk("rst2_state", 32'(state), 0);
    chk("rst2_umb_ae", 32'(umb_ae), 1);

    // Async reset with two words in flight.
    collect(2);
    #2 reset = 1;
    #1;
    chk("async_dn_push", 32'(dn_push), 0);
    chk("async_q_pop", 32'(q_pop), 0);
    chk("async_state", 32'(state), 0);
    q_empty = 4'hF;
    @(posedge clk); #1 reset = 0;
    pushes = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pushes += int'(dn_push);
    end
    chk("post_reset_pushes", 32'(pushes), 0);
    chk("post_reset_idle", 32'(idle), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_rr_scheduler.md
Name: fifo_rr_scheduler

Overview:
- Drains four source FIFOs into one shared downstream FIFO using round-robin arbitration.
- Issues one pop per cycle to the granted source and pushes the returned word downstream.
- Holds off when the downstream FIFO signals pause.
- Owns the init/idle/active/pause/error sequencing and distributes the almost-full/almost-empty thresholds to every FIFO it controls.

Parameters:
DATA_SIZE, 6, width of one data word
NUM_Q, 4, number of source FIFOs (fixed at 4 for this revision)
MAIN_QUEUE_SIZE, 3, FIFO address width; depth = 2**MAIN_QUEUE_SIZE

Ports:
clk  in  1  single clock, all logic on posedge
reset  in  1  asynchronous, active-high reset
init  in  1  level; while high, thresholds are (re)loaded
umb_af_in  in  DATA_SIZE  almost-full threshold to load
umb_ae_in  in  DATA_SIZE  almost-empty threshold to load
q_empty  in  NUM_Q  per-source FIFO empty flags
q_error  in  NUM_Q  per-source FIFO error flags
q_data  in  NUM_Q*DATA_SIZE  per-source registered read data; slice i = [i*DATA_SIZE +: DATA_SIZE]
q_enable  in  NUM_Q  per-source arbitration enable mask
dn_pause  in  1  downstream FIFO pause (almost-full)
dn_error  in  1  downstream FIFO error flag
q_pop  out  NUM_Q  one-hot read strobe to source FIFOs
dn_push  out  1  write strobe to downstream FIFO
dn_data  out  DATA_SIZE  word to downstream FIFO
umb_af  out  DATA_SIZE  registered almost-full threshold to all FIFOs
umb_ae  out  DATA_SIZE  registered almost-empty threshold to all FIFOs
state  out  3  current FSM state encoding
idle  out  1  high in IDLE with pipeline drained

Behaviour:
- Reset values: state=RESET, q_pop=0, dn_push=0, dn_data=0, umb_af=2**MAIN_QUEUE_SIZE-2, umb_ae=1, rr pointer=0, pipeline valid bits=0, idle=0.
- Reset asserted mid-operation clears all of the above immediately; in-flight words are dropped.
- States (encoding): RESET=0, INIT=1, IDLE=2, ACTIVE=3, PAUSE=4, ERROR=5.
- RESET -> INIT on the first clock after reset deasserts.
- INIT: umb_af/umb_ae load from the inputs every cycle init=1; no pops. INIT -> IDLE when init=0.
- IDLE: no pops; idle=1 once both pipeline stages are empty.
  - -> ACTIVE if any (~q_empty & q_enable) and dn_pause=0.
  - -> INIT if init=1.
- ACTIVE: each cycle grant the first requester (~q_empty & q_enable) at or after rr_ptr, wrapping 3 -> 0.
  - q_pop is combinational one-hot for the grant.
  - On a grant, rr_ptr <= grant+1 (mod NUM_Q).
  - No requester -> IDLE.
  - dn_pause=1 -> PAUSE, and q_pop is suppressed in that same cycle.
- PAUSE: no pops; in-flight words still complete. -> ACTIVE when dn_pause=0 and a requester exists; otherwise -> IDLE.
- ERROR: entered from any non-RESET state when any (q_error & q_enable) or dn_error is high. q_pop=0 and dn_push=0. Sticky until reset.
- Latency: pop in cycle N; source data valid on q_data in N+1 (captured at the end of N+1); dn_push=1 with dn_data in N+2. Fixed 2-cycle pop-to-push, full throughput of 1 word/cycle.
- The granted index is pipelined alongside the valid bit; the slice is selected in N+1.
- Downstream slack: at most 2 words are in flight after pause; umb_af must leave ≥2 free slots. The block does not enforce this.
- Simultaneous init and a requester while in IDLE: init wins.

Decomposition:
- Shared package holds the state encoding constants, NUM_Q, and the reset default thresholds.
- One natural sub-module, rr_arbiter_4: request vector + pointer in, one-hot grant + valid out, purely combinational.

Test Plan:
- Reset, then init=1 with umb_af=6 and umb_ae=2 for 2 cycles, then init=0 -> umb_af=6, umb_ae=2, state goes RESET->INIT->IDLE, idle=1.
- All four queues non-empty with enable=4'hF -> q_pop sequence 0001,0010,0100,1000,0001; dn_push first asserted 2 cycles after the first pop, with dn_data equal to the queue-0 word.
- Queue 2 disabled (q_enable=4'b1011), all non-empty -> grants cycle 0,1,3,0; q_pop[2] never asserted.
- dn_pause asserted mid-stream -> q_pop=0 the same cycle, exactly ≤2 further dn_push pulses, state=PAUSE; deassert -> ACTIVE resumes at the next queue in rotation.
- q_error[1]=1 while ACTIVE -> state=ERROR next cycle, all strobes low thereafter; stays there until reset pulses.
- reset asserted asynchronously with 2 words in flight -> dn_push and q_pop drop immediately without waiting for a clock, and no push occurs after reset is released.
